rw_burst_sequencer: RTL and testbench
=====================================

# rw_burst_sequencer

Parametrised successor to the single-word read/write transaction FSM in the USB host path. It accepts a read or write request from the OS side, issues an address-setup OUT transaction, then runs 1..N data transactions (IN for read, OUT for write). Each phase gets bounded retries and a response timeout, and the block returns a completion pulse with a status code. It sits between the OS request interface and the protocol/packet FSM that drives `in_trans`/`out_trans` and reports `success`/`failure`.

## Interface
- `DATA_W`, 64: data word width; must be ≥ `ADDR_W`.
- `ADDR_W`, 16: memory-page field width.
- `BEAT_W`, 4: width of the beat count; max burst is 2^BEAT_W−1 beats.
- `MAX_RETRY`, 3: extra attempts allowed per phase after a failure; 0 means no retry.
- `TIMEOUT`, 255: cycles to wait for a response before aborting; must be ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_b`  in  1: asynchronous, active-low reset.
- `read`, `write`  in  1: request strobes, sampled only in IDLE.
- `mempage`  in  ADDR_W: target page, latched at request acceptance.
- `num_beats`  in  BEAT_W: number of data beats, latched at acceptance; 0 is treated as 1.
- `data_from_OS`  in  DATA_W: write data, sampled at each write-beat issue.
- `data_from_device`  in  DATA_W: read data, valid in the `success` cycle of an IN phase.
- `success`, `failure`  in  1: single-cycle response from the protocol FSM.
- `in_trans`, `out_trans`  out  1: single-cycle transaction-issue pulses.
- `data_to_device`  out  DATA_W: address word or write word.
- `data_to_OS`  out  DATA_W: last read word.
- `os_data_valid`  out  1: pulses when `data_to_OS` is updated.
- `os_data_ack`  out  1: pulses when `data_from_OS` has been consumed.
- `done`  out  1: single-cycle completion pulse.
- `ok`  out  1: status, valid from the `done` cycle until the next acceptance.
- `err`  out  2: 00 none, 01 retries exhausted, 10 timeout; same validity as `ok`.
- `beats_done`  out  BEAT_W: count of beats completed successfully.

## Operation
- States: IDLE, ADDR_WAIT, DATA_WAIT.
- **IDLE acceptance.**
  - If `read` or `write` is high, latch the request; if both are high, `read` wins.
  - Latch `mempage` and `num_beats`; clear `beats_done`, `ok`, `err` and the retry counter.
  - Go to ADDR_WAIT.
- **ADDR_WAIT.**
  - Entry cycle: `out_trans`=1 and `data_to_device` = {zeros, `mempage`}.
  - On `success`, enter DATA_WAIT and issue beat 0.
- **DATA_WAIT, read.** Each issue is `in_trans`=1.
- **DATA_WAIT, write.** Each issue is `out_trans`=1, `data_to_device`←`data_from_OS`, and `os_data_ack`=1 in the same cycle.
- **Beat success.**
  - Increment `beats_done`.
  - For a read, also load `data_to_OS`←`data_from_device` and pulse `os_data_valid`.
  - If `beats_done` equals the latched beat count: pulse `done` with `ok`=1 and `err`=00, then return to IDLE.
  - Otherwise issue the next beat.
- **Failure in any phase.**
  - If retry count < `MAX_RETRY`: increment it and re-issue the same transaction. On a write re-issue, `data_to_device` is held and there is no `os_data_ack`.
  - Otherwise pulse `done` with `ok`=0 and `err`=01, then return to IDLE.
- **Retry counter.** Per phase; cleared on every successful phase.
- **Response sampling.**
  - `success` and `failure` are ignored in IDLE and in any cycle in which an issue pulse is high.
  - `success` has priority when both are high together.
- **Timeout.**
  - A counter clears at every issue and increments each subsequent cycle with no response.
  - Reaching `TIMEOUT` pulses `done` with `ok`=0 and `err`=10, then returns to IDLE. This path does not retry.
- **Outputs held.** `data_to_OS`, `data_to_device` and `beats_done` hold their values between updates and through IDLE.
- **Reset.**
  - Asynchronous, at any time including mid-burst: state goes to IDLE.
  - Every output goes to 0.
  - All counters clear.
  - No `done` is generated.

## Timing
- Request sampled at cycle t gives the address `out_trans` at t+1.
- Response at cycle s gives the next issue pulse, `os_data_valid` or `done` at s+1. Registered outputs give one cycle of latency.
- Failure at s gives the re-issue at s+1.
- Fastest 1-beat read: request t, issue t+1, success t+2, issue t+3, success t+4, `done` t+5.
- Back-to-back requests:
  - The `done` cycle is already IDLE, so a request asserted in the `done` cycle is accepted.
  - Its address issue appears one cycle later.
- Timeout example, `TIMEOUT`=4: issue at t and silence from t+1 to t+4 gives `done` at t+5.
- Issue pulses never last longer than one cycle. `in_trans` and `out_trans` are never high together.

## Test plan
- **Reset mid-burst.**
  - Stimulus: start a write with `num_beats`=4, then drop `rst_b` after 2 beats.
  - Response: all outputs read 0 at once with no `done`. A later read request runs normally.
- **Read burst.**
  - Stimulus: `num_beats`=3 and `mempage`=16'h1234; device returns words A, B, C.
  - Response: address OUT carries 0x1234; three `in_trans` pulses; `os_data_valid` pulses with `data_to_OS` = A, B, C in turn; `done` with `ok`=1 and `beats_done`=3.
- **Write burst.**
  - Stimulus: `num_beats`=2 with OS words D0, D1.
  - Response: `data_to_device` = D0 then D1, `os_data_ack` pulses exactly twice, `ok`=1.
- **Retry and exhaustion.**
  - Stimulus: `MAX_RETRY`=3. In one run, fail beat 0 three times and then succeed. In a second run, fail four times.
  - Response: first run completes with `ok`=1. Second run gives `done` after 4 issues with `err`=01; on a write, `data_to_device` is unchanged across retries.
- **Timeout.**
  - Stimulus: `TIMEOUT`=4, no response in ADDR_WAIT.
  - Response: `done` 5 cycles after the issue, with `err`=10 and `beats_done`=0.
- **Corner cases.**
  - `read` and `write` together, with `num_beats`=0: a 1-beat read results.
  - `success` and `failure` in the same cycle: treated as success.
  - A response during an issue-pulse cycle: ignored.
  - A new request in the `done` cycle: its address `out_trans` appears the next cycle.

Source files
------------

// File: rtl/rw_burst_sequencer.sv
// Read/write burst sequencer: address-setup OUT, then 1..N data beats with
// per-phase retry, response timeout and a completion pulse with status.
module rw_burst_sequencer #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BEAT_W    = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] mempage,
  input  logic [BEAT_W-1:0] num_beats,
  input  logic [DATA_W-1:0] data_from_OS,
  input  logic [DATA_W-1:0] data_from_device,
  input  logic              success,
  input  logic              failure,
  output logic              in_trans,
  output logic              out_trans,
  output logic [DATA_W-1:0] data_to_device,
  output logic [DATA_W-1:0] data_to_OS,
  output logic              os_data_valid,
  output logic              os_data_ack,
  output logic              done,
  output logic              ok,
  output logic [1:0]        err,
  output logic [BEAT_W-1:0] beats_done
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT} state_t;

  state_t               state;
  logic                 is_read;
  logic [BEAT_W-1:0]    target;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 issuing;
  logic [BEAT_W-1:0]    beats_next;

  assign issuing    = in_trans | out_trans;
  assign beats_next = beats_done + 1'b1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= IDLE;
      is_read        <= 1'b0;
      target         <= '0;
      retry_cnt      <= '0;
      tmo_cnt        <= '0;
      in_trans       <= 1'b0;
      out_trans      <= 1'b0;
      data_to_device <= '0;
      data_to_OS     <= '0;
      os_data_valid  <= 1'b0;
      os_data_ack    <= 1'b0;
      done           <= 1'b0;
      ok             <= 1'b0;
      err            <= 2'b00;
      beats_done     <= '0;
    end else begin
      in_trans      <= 1'b0;
      out_trans     <= 1'b0;
      os_data_valid <= 1'b0;
      os_data_ack   <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (read || write) begin
            is_read        <= read;
            target         <= (num_beats == '0) ? BEAT_W'(1) : num_beats;
            data_to_device <= DATA_W'(mempage);
            beats_done     <= '0;
            ok             <= 1'b0;
            err            <= 2'b00;
            retry_cnt      <= '0;
            tmo_cnt        <= '0;
            out_trans      <= 1'b1;
            state          <= ADDR_WAIT;
          end
        end
        ADDR_WAIT, DATA_WAIT: begin
          // Responses coinciding with our own issue pulse belong to nothing.
          if (!issuing) begin
            if (success) begin
              retry_cnt <= '0;
              tmo_cnt   <= '0;
              if (state == DATA_WAIT) begin
                beats_done <= beats_next;
                if (is_read) begin
                  data_to_OS    <= data_from_device;
                  os_data_valid <= 1'b1;
                end
              end
              if (state == DATA_WAIT && beats_next == target) begin
                done  <= 1'b1;
                ok    <= 1'b1;
                err   <= 2'b00;
                state <= IDLE;
              end else begin
                state <= DATA_WAIT;
                if (is_read) begin
                  in_trans <= 1'b1;
                end else begin
                  out_trans      <= 1'b1;
                  data_to_device <= data_from_OS;
                  os_data_ack    <= 1'b1;
                end
              end
            end else if (failure) begin
              if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 1'b1;
                tmo_cnt   <= '0;
                if (state == ADDR_WAIT || !is_read) out_trans <= 1'b1;
                else                                in_trans  <= 1'b1;
              end else begin
                done  <= 1'b1;
                ok    <= 1'b0;
                err   <= 2'b01;
                state <= IDLE;
              end
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              done  <= 1'b1;
              ok    <= 1'b0;
              err   <= 2'b10;
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_burst_sequencer.sv
// Directed bench for rw_burst_sequencer with MAX_RETRY=3 and TIMEOUT=4.
module tb_rw_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        read, write;
  logic [15:0] mempage;
  logic [3:0]  num_beats;
  logic [63:0] data_from_OS, data_from_device;
  logic        success, failure;
  logic        in_trans, out_trans;
  logic [63:0] data_to_device, data_to_OS;
  logic        os_data_valid, os_data_ack, done, ok;
  logic [1:0]  err;
  logic [3:0]  beats_done;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  rw_burst_sequencer #(
    .DATA_W(64), .ADDR_W(16), .BEAT_W(4), .MAX_RETRY(3), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_b(rst_b), .read(read), .write(write),
    .mempage(mempage), .num_beats(num_beats),
    .data_from_OS(data_from_OS), .data_from_device(data_from_device),
    .success(success), .failure(failure),
    .in_trans(in_trans), .out_trans(out_trans),
    .data_to_device(data_to_device), .data_to_OS(data_to_OS),
    .os_data_valid(os_data_valid), .os_data_ack(os_data_ack),
    .done(done), .ok(ok), .err(err), .beats_done(beats_done)
  );

  always @(negedge clk) if (os_data_ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a response for one cycle, then land in the following cycle.
  task automatic resp(input logic s, input logic f, input logic [63:0] d);
    success = s;
    failure = f;
    data_from_device = d;
    tick();
    success = 1'b0;
    failure = 1'b0;
  endtask

  task automatic request(input logic r, input logic w, input logic [15:0] mp, input logic [3:0] nb);
    read = r; write = w; mempage = mp; num_beats = nb;
    tick();
    read = 1'b0; write = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in"}, in_trans, 0);
    chk({tag, "_out"}, out_trans, 0);
    chk({tag, "_dtd"}, data_to_device, 0);
    chk({tag, "_dto"}, data_to_OS, 0);
    chk({tag, "_vld"}, os_data_valid, 0);
    chk({tag, "_ack"}, os_data_ack, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ok"}, ok, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_beats"}, beats_done, 0);
  endtask

  initial begin
    rst_b = 1'b0; read = 1'b0; write = 1'b0; mempage = '0; num_beats = '0;
    data_from_OS = '0; data_from_device = '0; success = 1'b0; failure = 1'b0;
    tick(); tick();
    chk_zero("rst");
    rst_b = 1'b1;
    tick();

    // Read burst, 3 beats at page 0x1234
    request(1, 0, 16'h1234, 4'd3);
    chk("rd_addr_out", out_trans, 1);
    chk("rd_addr_in", in_trans, 0);
    chk("rd_addr_dtd", data_to_device, 64'h1234);
    tick();
    chk("rd_addr_pulse1", out_trans, 0);
    resp(1, 0, '0);
    chk("rd_b0_in", in_trans, 1);
    chk("rd_b0_out", out_trans, 0);
    tick();
    resp(1, 0, 64'hAAAA_0000_0000_000A);
    chk("rd_a_vld", os_data_valid, 1);
    chk("rd_a_data", data_to_OS, 64'hAAAA_0000_0000_000A);
    chk("rd_a_beats", beats_done, 1);
    chk("rd_b1_in", in_trans, 1);
    chk("rd_a_done", done, 0);
    tick();
    resp(1, 0, 64'hBBBB_0000_0000_000B);
    chk("rd_b_data", data_to_OS, 64'hBBBB_0000_0000_000B);
    chk("rd_b_beats", beats_done, 2);
    chk("rd_b2_in", in_trans, 1);
    tick();
    resp(1, 0, 64'hCCCC_0000_0000_000C);
    chk("rd_c_vld", os_data_valid, 1);
    chk("rd_c_data", data_to_OS, 64'hCCCC_0000_0000_000C);
    chk("rd_done", done, 1);
    chk("rd_ok", ok, 1);
    chk("rd_err", err, 0);
    chk("rd_beats", beats_done, 3);
    chk("rd_no_issue", in_trans, 0);
    tick();
    chk("rd_done_pulse", done, 0);
    chk("rd_hold_dto", data_to_OS, 64'hCCCC_0000_0000_000C);

    // Write burst, 2 beats
    ack_cnt = 0;
    request(0, 1, 16'h00AB, 4'd2);
    chk("wr_addr_dtd", data_to_device, 64'hAB);
    tick();
    data_from_OS = 64'hD0D0_D0D0_D0D0_D0D0;
    resp(1, 0, '0);
    chk("wr_b0_out", out_trans, 1);
    chk("wr_b0_in", in_trans, 0);
    chk("wr_b0_dtd", data_to_device, 64'hD0D0_D0D0_D0D0_D0D0);
    chk("wr_b0_ack", os_data_ack, 1);
    data_from_OS = 64'hD1D1_D1D1_D1D1_D1D1;
    tick();
    resp(1, 0, '0);
    chk("wr_b1_dtd", data_to_device, 64'hD1D1_D1D1_D1D1_D1D1);
    chk("wr_b1_ack", os_data_ack, 1);
    chk("wr_b1_beats", beats_done, 1);
    tick();
    resp(1, 0, '0);
    chk("wr_done", done, 1);
    chk("wr_ok", ok, 1);
    chk("wr_beats", beats_done, 2);
    chk("wr_no_vld", os_data_valid, 0);
    tick();
    chk("wr_ack_count", ack_cnt, 2);

    // Retry: three failures then success on a 1-beat read
    request(1, 0, 16'h0007, 4'd1);
    tick();
    resp(1, 0, '0);
    chk("rt_b0_in", in_trans, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      resp(0, 1, '0);
      chk($sformatf("rt_reissue%0d", i), in_trans, 1);
      chk($sformatf("rt_nodone%0d", i), done, 0);
    end
    tick();
    resp(1, 0, 64'hEEEE);
    chk("rt_done", done, 1);
    chk("rt_ok", ok, 1);
    chk("rt_data", data_to_OS, 64'hEEEE);
    chk("rt_beats", beats_done, 1);

    // Exhaustion: four failures on a write beat
    data_from_OS = 64'h5757_0000_0000_0001;
    request(0, 1, 16'h0009, 4'd1);
    tick();
    resp(1, 0, '0);
    chk("ex_b0_dtd", data_to_device, 64'h5757_0000_0000_0001);
    data_from_OS = 64'h5757_0000_0000_0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      resp(0, 1, '0);
      chk($sformatf("ex_reissue%0d", i), out_trans, 1);
      chk($sformatf("ex_noack%0d", i), os_data_ack, 0);
      chk($sformatf("ex_dtd%0d", i), data_to_device, 64'h5757_0000_0000_0001);
    end
    tick();
    resp(0, 1, '0);
    chk("ex_done", done, 1);
    chk("ex_ok", ok, 0);
    chk("ex_err", err, 2'b01);
    chk("ex_no_issue", out_trans, 0);
    chk("ex_beats", beats_done, 0);

    // Timeout in ADDR_WAIT: done 5 cycles after the issue
    request(1, 0, 16'h0011, 4'd1);
    chk("to_issue", out_trans, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), done, 0);
    end
    tick();
    chk("to_done", done, 1);
    chk("to_ok", ok, 0);
    chk("to_err", err, 2'b10);
    chk("to_beats", beats_done, 0);

    // read+write with num_beats=0, response in issue cycle, success+failure
    request(1, 1, 16'h0042, 4'd0);
    chk("cc_addr_dtd", data_to_device, 64'h42);
    resp(1, 0, '0);
    chk("cc_ign_out", out_trans, 0);
    chk("cc_ign_in", in_trans, 0);
    resp(1, 1, '0);
    chk("cc_both_in", in_trans, 1);
    chk("cc_both_out", out_trans, 0);
    resp(1, 0, 64'h1111);
    chk("cc_ign2_done", done, 0);
    chk("cc_ign2_vld", os_data_valid, 0);
    resp(1, 1, 64'hF00D);
    chk("cc_done", done, 1);
    chk("cc_ok", ok, 1);
    chk("cc_data", data_to_OS, 64'hF00D);
    chk("cc_beats", beats_done, 1);
    // New request in the done cycle
    request(1, 0, 16'h0055, 4'd1);
    chk("b2b_out", out_trans, 1);
    chk("b2b_dtd", data_to_device, 64'h55);
    chk("b2b_ok_clr", ok, 0);
    tick();
    resp(1, 0, '0);
    tick();
    resp(1, 0, 64'h77);
    chk("b2b_done", done, 1);
    chk("b2b_ok", ok, 1);

    // Reset mid-burst: write 4 beats, reset after 2
    data_from_OS = 64'h3333;
    request(0, 1, 16'h0101, 4'd4);
    tick();
    resp(1, 0, '0);
    tick();
    resp(1, 0, '0);
    tick();
    resp(1, 0, '0);
    chk("mr_beats2", beats_done, 2);
    #2 rst_b = 1'b0;
    #1 chk_zero("mr");
    tick();
    chk("mr_done0", done, 0);
    tick();
    chk("mr_done1", done, 0);
    rst_b = 1'b1;
    tick();
    request(1, 0, 16'h0202, 4'd1);
    chk("mr_rd_out", out_trans, 1);
    chk("mr_rd_dtd", data_to_device, 64'h202);
    tick();
    resp(1, 0, '0);
    chk("mr_rd_in", in_trans, 1);
    tick();
    resp(1, 0, 64'h9999);
    chk("mr_rd_done", done, 1);
    chk("mr_rd_ok", ok, 1);
    chk("mr_rd_data", data_to_OS, 64'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
